multdiv_seq: RTL



---
 rtl/multdiv_seq.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/multdiv_seq.sv
// Iterative signed multiply (shift-add) / divide (restoring), WIDTH iterations per op.
// Optional build macro MULTDIV_DIV0_FAST_EN: a divide by zero completes after one iteration cycle.
module multdiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic               neg_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [2*WIDTH-1:0] acc_q;

    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] mul_acc_d;
    logic [2*WIDTH-1:0] mul_prod_s;
    logic               mul_exc_s;
    logic [WIDTH:0]     div_shift_s;
    logic               div_ge_s;
    logic [WIDTH-1:0]   div_rem_d;
    logic [WIDTH-1:0]   div_quo_d;
    logic [WIDTH-1:0]   div_res_s;
    logic               div_exc_s;
    logic               dvsr_zero_s;
    logic               div_skip_s;
    logic               start_mul_s;
    logic               start_div_s;
    logic               last_iter_s;

    // Unsigned magnitude; MIN_INT maps to 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        magnitude = v[WIDTH-1] ? ({WIDTH{1'b0}} - v) : v;
    endfunction

    assign start_mul_s = ctrl_MULT & ~ctrl_DIV;
    assign start_div_s = ctrl_DIV & ~ctrl_MULT;
    assign last_iter_s = (cnt_q == CNT_LAST);

`ifdef MULTDIV_DIV0_FAST_EN
    assign div_skip_s = dvsr_zero_s;
`else
    assign div_skip_s = 1'b0;
`endif

    // Multiply step: {hi, multiplier} accumulator shifted right, signed product from next value
    always_comb begin
        mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        mul_acc_d  = {mul_sum_s, acc_q[WIDTH-1:1]};
        mul_prod_s = neg_q ? ({(2*WIDTH){1'b0}} - mul_acc_d) : mul_acc_d;
        mul_exc_s  = ~((&mul_prod_s[2*WIDTH-1:WIDTH-1]) | ~(|mul_prod_s[2*WIDTH-1:WIDTH-1]));
    end

    // Restoring divide step; a positive quotient with the top bit set is the MIN_INT / -1 overflow
    always_comb begin
        dvsr_zero_s = (opnd_q == {WIDTH{1'b0}});
        div_shift_s = {rem_q, quo_q[WIDTH-1]};
        div_ge_s    = (div_shift_s >= {1'b0, opnd_q});
        div_rem_d   = WIDTH'(div_ge_s ? (div_shift_s - {1'b0, opnd_q}) : div_shift_s);
        div_quo_d   = {quo_q[WIDTH-2:0], div_ge_s};
        if (dvsr_zero_s) begin
            div_res_s = {WIDTH{1'b0}};
            div_exc_s = 1'b1;
        end else begin
            div_res_s = neg_q ? ({WIDTH{1'b0}} - div_quo_d) : div_quo_d;
            div_exc_s = ~neg_q & div_quo_d[WIDTH-1];
        end
    end

    // Control FSM with registered datapath and outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= {CW{1'b0}};
            neg_q          <= 1'b0;
            opnd_q         <= {WIDTH{1'b0}};
            rem_q          <= {WIDTH{1'b0}};
            quo_q          <= {WIDTH{1'b0}};
            acc_q          <= {(2*WIDTH){1'b0}};
            data_result    <= {WIDTH{1'b0}};
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    data_resultRDY <= 1'b0;
                    cnt_q          <= {CW{1'b0}};
                    if (start_mul_s) begin
                        state_q <= ST_MULT;
                        busy    <= 1'b1;
                        neg_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        opnd_q  <= magnitude(data_operandA);
                        acc_q   <= {{WIDTH{1'b0}}, magnitude(data_operandB)};
                    end else if (start_div_s) begin
                        state_q <= ST_DIV;
                        busy    <= 1'b1;
                        neg_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        opnd_q  <= magnitude(data_operandB);
                        quo_q   <= magnitude(data_operandA);
                        rem_q   <= {WIDTH{1'b0}};
                    end else begin
                        state_q <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                ST_MULT: begin
                    acc_q <= mul_acc_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_iter_s) begin
                        state_q        <= ST_DONE;
                        busy           <= 1'b0;
                        data_resultRDY <= 1'b1;
                        data_result    <= mul_prod_s[WIDTH-1:0];
                        data_exception <= mul_exc_s;
                    end
                end
                ST_DIV: begin
                    rem_q <= div_rem_d;
                    quo_q <= div_quo_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_iter_s || div_skip_s) begin
                        state_q        <= ST_DONE;
                        busy           <= 1'b0;
                        data_resultRDY <= 1'b1;
                        data_result    <= div_res_s;
                        data_exception <= div_exc_s;
                    end
                end
                default: begin
                    state_q        <= ST_IDLE;
                    busy           <= 1'b0;
                    data_resultRDY <= 1'b0;
                end
            endcase
        end
    end

endmodule
